// File: rtl/var_bw_mul_pkg.sv
// var_bw_mul_pkg: shared widths, iteration counts and FSM states for the variable bit-width multiplier
package var_bw_mul_pkg;
  localparam int OPW = 16;
  localparam int LANEW = 8;
  localparam int PW = 32;
  localparam int N16 = 16;
  localparam int N8 = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/var_bw_add.sv
// var_bw_add: combinational adder, one 16-bit sum or two independent 8-bit lane sums
module var_bw_add
  import var_bw_mul_pkg::*;
(
  input  logic              para_mode_add,
  input  logic [OPW-1:0]    a_add,
  input  logic [OPW-1:0]    b_add,
  output logic [OPW+1:0]    p_add
);
  // in lane mode each byte gets its own carry-out bit so no carry crosses into the upper lane
  always_comb
    p_add = para_mode_add
      ? {{1'b0, a_add[OPW-1:LANEW]} + {1'b0, b_add[OPW-1:LANEW]},
         {1'b0, a_add[LANEW-1:0]} + {1'b0, b_add[LANEW-1:0]}}
      : {1'b0, {1'b0, a_add} + {1'b0, b_add}};
endmodule

// File: rtl/var_bw_mul_seq.sv
// var_bw_mul_seq: sequential shift-and-add multiplier, one 16x16 or two 8x8 unsigned products
module var_bw_mul_seq
  import var_bw_mul_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           para_mode,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PW-1:0]  p
);
  state_t state, state_nxt;
  logic mode, last;
  logic [OPW-1:0] mcand, mlt, acc, b_add, acc_nxt, mlt_nxt;
  logic [OPW+1:0] p_add;
  logic [4:0] cnt;

  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign last = cnt == (mode ? 5'(N8 - 1) : 5'(N16 - 1));

  var_bw_add u_add (
    .para_mode_add(mode),
    .a_add(acc),
    .b_add(b_add),
    .p_add(p_add)
  );

  // partial product selection and the shift that folds each sum back into acc/mlt
  always_comb begin
    b_add = mode ? {mlt[LANEW] ? mcand[OPW-1:LANEW] : 8'h00, mlt[0] ? mcand[LANEW-1:0] : 8'h00}
                 : (mlt[0] ? mcand : '0);
    acc_nxt = mode ? {p_add[17:10], p_add[8:1]} : p_add[16:1];
    mlt_nxt = mode ? {p_add[9], mlt[15:9], p_add[0], mlt[7:1]} : {p_add[0], mlt[15:1]};
  end

  // next-state logic: accept in IDLE, iterate in RUN, hold result in DONE until drained
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (in_valid ? RUN : IDLE)
              : state == RUN  ? (last ? DONE : RUN)
              : (out_ready ? IDLE : DONE);
  end

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;

  // operand capture, iteration and result register; lane results are regrouped as {hi product, lo product}
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode <= 1'b0;
      mcand <= '0;
      mlt <= '0;
      acc <= '0;
      cnt <= '0;
      p <= '0;
    end else if (state == IDLE && in_valid) begin
      mode <= para_mode;
      mcand <= a;
      mlt <= b;
      acc <= '0;
      cnt <= '0;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      mlt <= mlt_nxt;
      cnt <= cnt + 5'd1;
      if (last)
        p <= mode ? {acc_nxt[15:8], mlt_nxt[15:8], acc_nxt[7:0], mlt_nxt[7:0]} : {acc_nxt, mlt_nxt};
    end
endmodule

// File: tb/tb_var_bw_mul_seq.sv
// tb_var_bw_mul_seq: directed self-checking bench for var_bw_mul_seq
module tb_var_bw_mul_seq;
  logic clk = 0, rst = 1, in_valid = 0, para_mode = 0, out_ready = 0;
  logic [15:0] a = 0, b = 0;
  logic in_ready, out_valid;
  logic [31:0] p;
  int tests = 0, fails = 0, cyc = 0;

  var_bw_mul_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .para_mode(para_mode),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic run_op(input logic m, input logic [15:0] x, input logic [15:0] y, output int lat, output int at);
    int w = 0;
    lat = -1;
    at = -1;
    @(negedge clk);
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) return;
    in_valid = 1; para_mode = m; a = x; b = y;
    @(posedge clk); #1;
    at = cyc;
    in_valid = 0; a = 16'hDEAD; b = 16'hBEEF; para_mode = ~m;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic drain;
    @(negedge clk);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL reset_hs: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid); end
    tests++; if (p !== 32'h0) begin fails++; $display("FAIL reset_p: got %h want 00000000", p); end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_hs: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid); end
  endtask

  task automatic test_mul16;
    int lat, at;
    run_op(0, 16'h1234, 16'h5678, lat, at);
    tests++; if (lat !== 16) begin fails++; $display("FAIL m16_lat: got %0d want 16", lat); end
    tests++; if (p !== 32'h06260060) begin fails++; $display("FAIL m16_p: got %h want 06260060", p); end
    drain();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL m16_drain: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid); end
    run_op(0, 16'hFFFF, 16'hFFFF, lat, at);
    tests++; if (p !== 32'hFFFE0001) begin fails++; $display("FAIL m16_max: got %h want fffe0001", p); end
    drain();
  endtask

  task automatic test_para;
    int lat, at;
    run_op(1, 16'hFFFF, 16'hFFFF, lat, at);
    tests++; if (lat !== 8) begin fails++; $display("FAIL para_lat: got %0d want 8", lat); end
    tests++; if (p !== 32'hFE01FE01) begin fails++; $display("FAIL para_max: got %h want fe01fe01", p); end
    drain();
    run_op(1, 16'h0310, 16'h0205, lat, at);
    tests++; if (p !== 32'h00060050) begin fails++; $display("FAIL para_lanes: got %h want 00060050", p); end
    drain();
  endtask

  task automatic test_backpressure;
    int lat, at;
    logic bad = 0;
    run_op(0, 16'h00FF, 16'h0101, lat, at);
    tests++; if (p !== 32'h0000FFFF || lat !== 16) begin fails++; $display("FAIL bp_result: got p=%h lat=%0d want p=0000ffff lat=16", p, lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      a = 16'h0011; b = 16'h0022; para_mode = 0;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || p !== 32'h0000FFFF) bad = 1;
    end
    in_valid = 0;
    tests++; if (bad) begin fails++; $display("FAIL bp_hold: got vld=%b rdy=%b p=%h want vld=1 rdy=0 p=0000ffff", out_valid, in_ready, p); end
    drain();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid); end
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad = 1;
    end
    tests++; if (bad) begin fails++; $display("FAIL bp_refused: got vld=1 want vld=0 (refused operand was queued)"); end
  endtask

  task automatic test_reset_mid_run;
    int lat, at;
    logic bad = 0;
    @(negedge clk);
    in_valid = 1; para_mode = 0; a = 16'h1234; b = 16'h5678;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (7) @(posedge clk);
    #2 rst = 1;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || p !== 32'h0) begin fails++; $display("FAIL mid_rst: got vld=%b rdy=%b p=%h want vld=0 rdy=1 p=00000000", out_valid, in_ready, p); end
    @(negedge clk);
    @(negedge clk); rst = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad = 1;
    end
    tests++; if (bad) begin fails++; $display("FAIL mid_rst_no_pulse: got vld=1 want vld=0"); end
    run_op(0, 16'd3, 16'd5, lat, at);
    tests++; if (p !== 32'd15 || lat !== 16) begin fails++; $display("FAIL mid_rst_fresh: got p=%h lat=%0d want p=0000000f lat=16", p, lat); end
    drain();
  endtask

  task automatic test_zero;
    int lat, at;
    run_op(0, 16'h0000, 16'hABCD, lat, at);
    tests++; if (p !== 32'h0 || lat !== 16) begin fails++; $display("FAIL zero16: got p=%h lat=%0d want p=00000000 lat=16", p, lat); end
    drain();
    run_op(0, 16'h0000, 16'h0000, lat, at);
    tests++; if (p !== 32'h0 || lat !== 16) begin fails++; $display("FAIL zero16_both: got p=%h lat=%0d want p=00000000 lat=16", p, lat); end
    drain();
    run_op(1, 16'h0005, 16'h0007, lat, at);
    tests++; if (p !== 32'h00000023) begin fails++; $display("FAIL para_small: got %h want 00000023", p); end
    drain();
    run_op(1, 16'h1234, 16'h0000, lat, at);
    tests++; if (p !== 32'h0 || lat !== 8) begin fails++; $display("FAIL zero_para: got p=%h lat=%0d want p=00000000 lat=8", p, lat); end
    drain();
  endtask

  task automatic test_back_to_back;
    int lat1, at1, lat2, at2;
    @(negedge clk);
    out_ready = 1;
    run_op(0, 16'h0203, 16'h0405, lat1, at1);
    tests++; if (p !== 32'h0008160F || lat1 !== 16) begin fails++; $display("FAIL b2b_16: got p=%h lat=%0d want p=0008160f lat=16", p, lat1); end
    run_op(1, 16'h0203, 16'h0405, lat2, at2);
    tests++; if (p !== 32'h0008000F || lat2 !== 8) begin fails++; $display("FAIL b2b_para: got p=%h lat=%0d want p=0008000f lat=8", p, lat2); end
    tests++; if (at2 - at1 !== 18) begin fails++; $display("FAIL b2b_gap: got %0d want 18", at2 - at1); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL b2b_end: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready); end
    out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_mul16();
    test_para();
    test_backpressure();
    test_reset_mid_run();
    test_zero();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
